// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : PS/2 host-to-device byte transmitter (inhibit, request, 8 data
//            bits LSB first, odd parity, stop, device acknowledge) with a
//            per-edge timeout. Macro PS2TX_ACK_CHECK_EN turns a high ACK
//            sample into an error instead of done.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2800,
    parameter int TIMEOUT_CYCLES = 420000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_BITS    = 3'd3;
    localparam logic [2:0] S_STOP    = 3'd4;
    localparam logic [2:0] S_ACK     = 3'd5;
    localparam logic [2:0] S_FINISH  = 3'd6;

    localparam int c_INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_INH_W-1:0] c_INH_LAST = c_INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

`ifdef PS2TX_ACK_CHECK_EN
    localparam logic c_ACK_CHECK = 1'b1;
`else
    localparam logic c_ACK_CHECK = 1'b0;
`endif

    logic [2:0]         r_state;
    logic [7:0]         r_data;
    logic [3:0]         r_bit_cnt;
    logic [c_INH_W-1:0] r_inh_cnt;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_clk_meta, r_clk_sync, r_clk_prev;
    logic               r_data_meta, r_data_sync;
    logic               r_clk_oe, r_data_oe, r_busy, r_done, r_error;

    logic w_fall;
    logic w_parity;
    logic w_timeout;
    logic w_ack_bad;

    assign w_fall    = r_clk_prev & ~r_clk_sync;
    assign w_parity  = ~^r_data;
    assign w_timeout = (r_tmo_cnt == c_TMO_LAST) && !w_fall;
    assign w_ack_bad = c_ACK_CHECK & r_data_sync;

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;

    // Synchronizers reset to the idle-high line level so no false edge appears
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= ps2_clk_in;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= ps2_data_in;
            r_data_sync <= r_data_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_data    <= 8'h00;
            r_bit_cnt <= 4'd0;
            r_inh_cnt <= '0;
            r_tmo_cnt <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_busy    <= 1'b0;
                    if (tx_start) begin
                        r_data    <= tx_data;
                        r_inh_cnt <= '0;
                        r_clk_oe  <= 1'b1;
                        r_data_oe <= (INHIBIT_CYCLES == 1);
                        r_busy    <= 1'b1;
                        r_state   <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    // Start bit is already driven during the final inhibit cycle
                    if (r_inh_cnt == c_INH_LAST) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= S_REQ;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + 1'b1;
                        if (r_inh_cnt + 1'b1 == c_INH_LAST) begin
                            r_data_oe <= 1'b1;
                        end
                    end
                end
                S_REQ, S_BITS, S_STOP, S_ACK: begin
                    if (w_fall) begin
                        r_tmo_cnt <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                    if (w_timeout) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_busy    <= 1'b0;
                        r_error   <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (w_fall) begin
                        case (r_state)
                            S_REQ: begin
                                r_data_oe <= ~r_data[0];
                                r_bit_cnt <= 4'd1;
                                r_state   <= S_BITS;
                            end
                            S_BITS: begin
                                if (r_bit_cnt == 4'd8) begin
                                    r_data_oe <= ~w_parity;
                                    r_state   <= S_STOP;
                                end else begin
                                    r_data_oe <= ~r_data[r_bit_cnt[2:0]];
                                    r_bit_cnt <= r_bit_cnt + 4'd1;
                                end
                            end
                            S_STOP: begin
                                r_data_oe <= 1'b0;
                                r_state   <= S_ACK;
                            end
                            default: begin
                                // Result is registered here so it shows during FINISH
                                r_done  <= ~w_ack_bad;
                                r_error <= w_ack_bad;
                                r_state <= S_FINISH;
                            end
                        endcase
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Bench for ps2_host_tx with an open-collector PS/2 device model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int TMO = 600;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       busy, done, error;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int checks = 0;
    int errors = 0;
    int done_cycles = 0;
    int err_cycles = 0;
    int both_cycles = 0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .tx_data(tx_data), .tx_start(tx_start),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cycles++;
        if (error === 1'b1) err_cycles++;
        if (done === 1'b1 && error === 1'b1) both_cycles++;
    end

    // Reference: frame = {stop, odd parity, d7..d0}, parity from a ones count
    function automatic logic [9:0] ref_frame(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d};
    endfunction

    function automatic bit ref_error(input bit ack_low);
`ifdef PS2TX_ACK_CHECK_EN
        return !ack_low;
`else
        return 1'b0;
`endif
    endfunction

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Device: waits for the request-to-send, then clocks nedges edges
    task automatic device_clock(input int nedges, input bit ack_low, input int half,
                                output logic [9:0] rx, output bit ok);
        int t;
        rx = '0;
        t  = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && t < INH + 100) begin
            @(negedge clk);
            t++;
        end
        ok = (t < INH + 100);
        if (!ok) return;
        repeat (half) @(negedge clk);
        for (int k = 1; k <= nedges; k++) begin
            dev_clk_low = 1'b1;
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (half / 2) @(negedge clk);
            if (k <= 10) rx[k-1] = ps2_data_in;
            if (k == 10 && ack_low) dev_data_low = 1'b1;
            repeat (half - half / 2) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack_low, input int half,
                             input bit intrude, output logic [9:0] rx, output bit ok,
                             output int ddone, output int derr);
        int d0, e0;
        d0 = done_cycles;
        e0 = err_cycles;
        send(d);
        if (intrude) begin
            repeat (5) @(negedge clk);
            send(~d);
        end
        device_clock(11, ack_low, half, rx, ok);
        repeat (10) @(negedge clk);
        ddone = done_cycles - d0;
        derr  = err_cycles - e0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        tx_start = 1'b1;
        tx_data  = 8'hAA;
        repeat (3) @(negedge clk);
        checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe); end
        checks++; if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b expected 0", ps2_data_oe); end
        checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b expected 000", {busy, done, error}); end
        reset    = 1'b0;
        tx_start = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: got busy=%b clk_oe=%b expected 0 0", busy, ps2_clk_oe); end
    endtask

    task automatic test_known_bytes();
        logic [7:0] bytes [3] = '{8'hED, 8'h07, 8'h00};
        logic [9:0] rx;
        bit ok;
        int dd, de;
        for (int i = 0; i < 3; i++) begin
            run_frame(bytes[i], 1'b1, 20, 1'b0, rx, ok, dd, de);
            checks++; if (!ok) begin errors++; $display("FAIL known_rts[%0d]: got no request expected request", i); end
            checks++; if (rx !== ref_frame(bytes[i])) begin errors++; $display("FAIL known_frame[%0d]: got %h expected %h", i, rx, ref_frame(bytes[i])); end
            checks++; if (dd !== 1 || de !== 0) begin errors++; $display("FAIL known_result[%0d]: got done=%0d err=%0d expected 1 0", i, dd, de); end
            checks++; if ({busy, ps2_clk_oe, ps2_data_oe} !== 3'b000) begin errors++; $display("FAIL known_idle[%0d]: got %b expected 000", i, {busy, ps2_clk_oe, ps2_data_oe}); end
            if (i == 0) begin
                checks++; if (rx !== 10'h3ED) begin errors++; $display("FAIL ed_serial: got %h expected 3ed", rx); end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [9:0] rx;
        bit ok, ack;
        int dd, de, half;
        for (int i = 0; i < 6; i++) begin
            d    = 8'($urandom);
            ack  = ($urandom_range(0, 3) != 0);
            half = $urandom_range(10, 30);
            run_frame(d, ack, half, 1'b0, rx, ok, dd, de);
            checks++; if (rx !== ref_frame(d)) begin errors++; $display("FAIL rand_frame[%0d]: got %h expected %h", i, rx, ref_frame(d)); end
            checks++; if (de !== int'(ref_error(ack)) || dd !== int'(!ref_error(ack))) begin
                errors++; $display("FAIL rand_result[%0d]: got done=%0d err=%0d expected %0d %0d", i, dd, de, !ref_error(ack), ref_error(ack));
            end
        end
    endtask

    task automatic test_nack();
        logic [9:0] rx;
        bit ok;
        int dd, de;
        run_frame(8'hF3, 1'b0, 16, 1'b0, rx, ok, dd, de);
        checks++; if (de !== int'(ref_error(1'b0)) || dd !== int'(!ref_error(1'b0))) begin
            errors++; $display("FAIL nack_result: got done=%0d err=%0d expected %0d %0d", dd, de, !ref_error(1'b0), ref_error(1'b0));
        end
    endtask

    task automatic test_timeout();
        int hi, rel, d0, e0;
        d0 = done_cycles;
        e0 = err_cycles;
        send(8'h5A);
        hi = 0;
        while (ps2_clk_oe === 1'b1 && hi < INH + 10) begin hi++; @(negedge clk); end
        checks++; if (hi !== INH) begin errors++; $display("FAIL inhibit_len: got %0d expected %0d", hi, INH); end
        rel = 0;
        while (error !== 1'b1 && rel < TMO + 10) begin rel++; @(negedge clk); end
        checks++; if (rel !== TMO) begin errors++; $display("FAIL timeout_len: got %0d expected %0d", rel, TMO); end
        checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL timeout_oe: got %b expected 00", {ps2_clk_oe, ps2_data_oe}); end
        repeat (5) @(negedge clk);
        checks++; if (err_cycles - e0 !== 1 || done_cycles - d0 !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_result: got err=%0d done=%0d busy=%b expected 1 0 0", err_cycles - e0, done_cycles - d0, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] rx;
        bit ok;
        int dd, de, d0, e0;
        d0 = done_cycles;
        e0 = err_cycles;
        send(8'h3C);
        device_clock(4, 1'b1, 20, rx, ok);
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin errors++; $display("FAIL midreset_release: got %b expected 000", {ps2_clk_oe, ps2_data_oe, busy}); end
        reset = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (done_cycles - d0 !== 0 || err_cycles - e0 !== 0) begin errors++; $display("FAIL midreset_pulse: got done=%0d err=%0d expected 0 0", done_cycles - d0, err_cycles - e0); end
        run_frame(8'hF4, 1'b1, 20, 1'b0, rx, ok, dd, de);
        checks++; if (rx !== ref_frame(8'hF4) || dd !== 1 || de !== 0) begin
            errors++; $display("FAIL midreset_resend: got frame=%h done=%0d err=%0d expected %h 1 0", rx, dd, de, ref_frame(8'hF4));
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] rx;
        bit ok;
        int dd, de;
        run_frame(8'hA6, 1'b1, 18, 1'b1, rx, ok, dd, de);
        checks++; if (rx !== ref_frame(8'hA6)) begin errors++; $display("FAIL b2b_frame: got %h expected %h", rx, ref_frame(8'hA6)); end
        checks++; if (dd !== 1 || de !== 0) begin errors++; $display("FAIL b2b_result: got done=%0d err=%0d expected 1 0", dd, de); end
        repeat (INH + 10) @(negedge clk);
        checks++; if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL b2b_no_restart: got busy=%b clk_oe=%b expected 0 0", busy, ps2_clk_oe); end
    endtask

    initial begin
        test_reset();
        test_known_bytes();
        test_random();
        test_nack();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        checks++; if (both_cycles !== 0) begin errors++; $display("FAIL done_error_overlap: got %0d expected 0", both_cycles); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter: INHIBIT_CYCLES, 2800, clk cycles ps2 clock is held low before start bit (100 us at 28 MHz).
REQ-002 SHALL have parameter: TIMEOUT_CYCLES, 420000, max clk cycles allowed between releasing the ps2 clock and any device falling edge, and between consecutive falling edges (15 ms at 28 MHz).
REQ-003 SHALL have port: clk  input  1  system clock, single clock domain.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: ps2_clk_in  input  1  sampled PS/2 clock line, asynchronous.
REQ-006 SHALL have port: ps2_data_in  input  1  sampled PS/2 data line, asynchronous.
REQ-007 SHALL have port: ps2_clk_oe  output  1  1 = drive PS/2 clock low; 0 = release.
REQ-008 SHALL have port: ps2_data_oe  output  1  1 = drive PS/2 data low; 0 = release.
REQ-009 SHALL have port: tx_data  input  8  command byte to send, e.g. 0xED LED set.
REQ-010 SHALL have port: tx_start  input  1  one-cycle request; tx_data is captured on the same cycle.
REQ-011 SHALL have port: busy  output  1  high from the cycle after an accepted tx_start until return to IDLE.
REQ-012 SHALL have port: done  output  1  one-cycle pulse on successful completion.
REQ-013 SHALL have port: error  output  1  one-cycle pulse on timeout or NACK.

Function
REQ-014 SHALL pass ps2_clk_in and ps2_data_in through 2-FF synchronizers; a falling edge is synced-clock 1 then 0 on consecutive cycles.
REQ-015 SHALL compute the parity bit as odd parity: XNOR-reduction of the captured byte.
REQ-016 SHALL implement states IDLE, INHIBIT, REQ, BITS, STOP, ACK, FINISH.
REQ-017 IDLE: oe outputs 0, busy 0; tx_start=1 -> capture tx_data, go to INHIBIT; tx_start is ignored in every other state.
REQ-018 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; on the last cycle set ps2_data_oe=1 (start bit), then go to REQ.
REQ-019 REQ: ps2_clk_oe=0, ps2_data_oe=1; first falling edge -> present data bit 0 (ps2_data_oe = ~bit), go to BITS.
REQ-020 BITS: each further falling edge presents the next bit in order d1..d7, then parity; after parity is presented go to STOP; bit counter is 4 bits wide.
REQ-021 STOP: next falling edge -> ps2_data_oe=0 (stop bit, line released), go to ACK.
REQ-022 ACK: next falling edge (11th) -> sample synced data; go to FINISH.
REQ-023 FINISH: assert done (or error per REQ-030) for one cycle, go to IDLE; busy is 0 in the cycle after FINISH.
REQ-024 Timeout counter SHALL clear on entry to REQ and on every falling edge; reaching TIMEOUT_CYCLES in REQ/BITS/STOP/ACK -> oe outputs 0, error pulse, IDLE.
REQ-025 Outputs ps2_clk_oe, ps2_data_oe, done, error SHALL be registered; done and error SHALL never be high together.

Reset
REQ-026 reset=1 SHALL force state IDLE, ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, error=0 and clear counters at the next clk edge.
REQ-027 Reset mid-transfer SHALL release both lines on the next edge with no done/error pulse.
REQ-028 tx_start asserted together with reset SHALL be ignored.

Configuration
REQ-029 Macro PS2TX_ACK_CHECK_EN SHALL select acknowledge checking.
REQ-030 Defined: ACK-sampled data 0 -> done; data 1 -> error. Undefined: the ACK sample is ignored and FINISH always pulses done; timeout still yields error.

Verification
REQ-031 tx_data=0xED with device model clocking at 12.5 kHz and ACK low -> serial d0..d7 = 1,0,1,1,0,1,1,1, parity 1, stop 1, done pulse, error 0.
REQ-032 tx_data=0x07 -> parity bit 0; tx_data=0x00 -> parity bit 1; done each time.
REQ-033 tx_start with no device clocking -> ps2_clk_oe high exactly 2800 cycles, then error pulse 420000 cycles after clock release, both oe 0.
REQ-034 With PS2TX_ACK_CHECK_EN defined, device leaves data high at 11th edge -> error pulse, no done; macro undefined -> done.
REQ-035 reset pulse after 4th falling edge -> both oe 0 the next cycle, busy 0, no done/error; subsequent 0xF4 send completes with done.
REQ-036 Second tx_start while busy -> ignored, first byte transmitted unchanged, single done pulse.
